// File: rtl/display_scan_controller_pkg.sv
// ----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the four-digit error display scan controller:
//   - scan FSM state encoding
//   - msg_sel codes routed to the per-message segment decoders
//   - bit positions of the sensor error flags
//   - pick_msg(): lowest-index pending error -> msg_sel code
// ----------------------------------------------------------------------------
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_e;

    typedef enum logic [1:0] {
        MSG_NORMAL = 2'b00,
        MSG_ESR    = 2'b01,
        MSG_AGUA   = 2'b10,
        MSG_TEMP   = 2'b11
    } msg_sel_e;

    localparam int unsigned ERR_SR   = 0;
    localparam int unsigned ERR_AGUA = 1;
    localparam int unsigned ERR_TEMP = 2;

    // Lowest set bit wins, so the SR sensor message has priority over the others.
    function automatic logic [1:0] pick_msg(input logic [2:0] err);
        logic [1:0] sel;
        if (err[ERR_SR]) begin
            sel = MSG_ESR;
        end else if (err[ERR_AGUA]) begin
            sel = MSG_AGUA;
        end else if (err[ERR_TEMP]) begin
            sel = MSG_TEMP;
        end else begin
            sel = MSG_NORMAL;
        end
        return sel;
    endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// ----------------------------------------------------------------------------
// display_scan_controller_if
// Control/status bundle between the machine control side and the scan
// controller.
//   enable          : scanning allowed (to controller)
//   erro_in[2:0]    : error flag levels, bit0 SR, bit1 water, bit2 temp
//   ack[2:0]        : per-bit clear of latched errors
//   saida1Contador  : digit index MSB (from controller)
//   saida2Contador  : digit index LSB
//   digito_n[3:0]   : active-low digit enables
//   msg_sel[1:0]    : message decoder routing
//   erro_pend       : any latched error
// master = control/bench side, slave = scan controller.
// ----------------------------------------------------------------------------
interface display_scan_controller_if;
    logic       enable;
    logic [2:0] erro_in;
    logic [2:0] ack;
    logic       saida1Contador;
    logic       saida2Contador;
    logic [3:0] digito_n;
    logic [1:0] msg_sel;
    logic       erro_pend;

    modport master (
        output enable, erro_in, ack,
        input  saida1Contador, saida2Contador, digito_n, msg_sel, erro_pend
    );

    modport slave (
        input  enable, erro_in, ack,
        output saida1Contador, saida2Contador, digito_n, msg_sel, erro_pend
    );
endinterface

// File: rtl/display_scan_controller_prescaler_slot.sv
// ----------------------------------------------------------------------------
// prescaler_slot
// Digit-slot cycle counter. Counts 0..PRESCALE-1 and wraps by itself.
//   clk, reset   : clock, asynchronous active-high reset
//   clr_i        : synchronous clear (holds the count at 0)
//   blank_done_o : count == BLANK-1 (last blanked cycle of the slot)
//   slot_done_o  : count == PRESCALE-1 (last cycle of the slot)
// ----------------------------------------------------------------------------
module prescaler_slot #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned BLANK    = 2000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic blank_done_o,
    output logic slot_done_o
);
    localparam int unsigned   CW         = $clog2(PRESCALE);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign blank_done_o = (cnt_q == BLANK_LAST);
    assign slot_done_o  = (cnt_q == SLOT_LAST);

    // Next count: clear on request or at end of slot, otherwise increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || slot_done_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/display_scan_controller.sv
// ----------------------------------------------------------------------------
// display_scan_controller
// Time-multiplexed scan of the four-digit 7-segment error display with an
// anti-ghosting blank gap at the start of every digit slot, sensor error
// latching, frame-stable message selection and blinking while errors pend.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : display_scan_controller_if.slave (enable, erro_in, ack in;
//                digit index, digito_n, msg_sel, erro_pend out, all registered)
// ----------------------------------------------------------------------------
module display_scan_controller
    import display_pkg::*;
#(
    parameter int unsigned PRESCALE    = 50000,
    parameter int unsigned BLANK       = 2000,
    parameter int unsigned BLINK_SCANS = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    display_scan_controller_if.slave      bus
);
    localparam int unsigned   BW         = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SCANS - 1);

    scan_state_e   state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    dig_q, dig_d;
    logic [1:0]    msg_q, msg_d;
    logic          pend_q, pend_d;
    logic [2:0]    err_q, err_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_off_q, blink_off_d;
    logic          wrap_s;
    logic          leave_idle_s;
    logic          presc_clr_s;
    logic          blank_done_s;
    logic          slot_done_s;

    // Counter is held at zero outside an active scan so BLANK always starts at 0.
    assign presc_clr_s = !bus.enable || (state_q == ST_IDLE);

    prescaler_slot #(
        .PRESCALE (PRESCALE),
        .BLANK    (BLANK)
    ) u_prescaler (
        .clk          (clk),
        .reset        (reset),
        .clr_i        (presc_clr_s),
        .blank_done_o (blank_done_s),
        .slot_done_o  (slot_done_s)
    );

    // Scan FSM next state and digit index; the index only moves on BLANK entry.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        wrap_s       = 1'b0;
        leave_idle_s = 1'b0;
        if (!bus.enable) begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d      = ST_BLANK;
                    leave_idle_s = 1'b1;
                end
                ST_BLANK: begin
                    if (blank_done_s) begin
                        state_d = ST_SHOW;
                    end else begin
                        state_d = ST_BLANK;
                    end
                end
                ST_SHOW: begin
                    if (slot_done_s) begin
                        state_d = ST_BLANK;
                        idx_d   = idx_q + 2'd1;
                        wrap_s  = (idx_q == 2'd3);
                    end else begin
                        state_d = ST_SHOW;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = 2'd0;
                end
            endcase
        end
    end

    // Error latch, message select, blink tracking and digit enable outputs.
    always_comb begin
        // Set has priority over acknowledge.
        err_d       = bus.erro_in | (err_q & ~bus.ack);
        pend_d      = |err_q;
        msg_d       = msg_q;
        blink_cnt_d = blink_cnt_q;
        blink_off_d = blink_off_q;
        dig_d       = 4'b1111;

        // Message changes only between frames so a frame never mixes messages.
        if (wrap_s || leave_idle_s) begin
            msg_d = pick_msg(err_q);
        end else begin
            msg_d = msg_q;
        end

        if (wrap_s) begin
            if (err_q == 3'b000) begin
                blink_cnt_d = '0;
                blink_off_d = 1'b0;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_off_d = !blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end else begin
            blink_cnt_d = blink_cnt_q;
        end

        // Blink only blanks the segments; the index keeps cycling underneath.
        if ((state_d == ST_SHOW) && !(pend_q && blink_off_q)) begin
            dig_d = ~(4'b0001 << idx_d);
        end else begin
            dig_d = 4'b1111;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            dig_q       <= 4'b1111;
            msg_q       <= MSG_NORMAL;
            pend_q      <= 1'b0;
            err_q       <= 3'b000;
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dig_q       <= dig_d;
            msg_q       <= msg_d;
            pend_q      <= pend_d;
            err_q       <= err_d;
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
        end
    end

    assign bus.saida1Contador = idx_q[1];
    assign bus.saida2Contador = idx_q[0];
    assign bus.digito_n       = dig_q;
    assign bus.msg_sel        = msg_q;
    assign bus.erro_pend      = pend_q;
endmodule
